// File: rtl/acc32_pkg.sv
// Shared types and widths for the streaming 32-bit accumulator.
// Imported by the adder slice, the handshake interface and the top.
package acc32_pkg;

  localparam int HALF_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/acc32_stream_if.sv
// Word-in / sum-out handshake bundle for acc32_stream.
// The master drives words and accepts results; the slave is the accumulator.
interface acc32_stream_if
  import acc32_pkg::*;
#(
  parameter int CNT_W = 8
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_sum;
  logic              out_ovf;
  logic [CNT_W-1:0]  out_cnt;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, out_cnt
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, out_cnt
  );

endinterface

// File: rtl/add16.sv
// 16-bit ripple-carry adder slice used for each half of the accumulator.
// Purely combinational; carry-in and carry-out are exposed for chaining.
module add16
  import acc32_pkg::*;
(
  input  logic [HALF_W-1:0] a_i,
  input  logic [HALF_W-1:0] b_i,
  input  logic              cin_i,
  output logic [HALF_W-1:0] sum_o,
  output logic              cout_o
);

  logic c;

  always_comb begin
    c     = cin_i;
    sum_o = '0;
    for (int i = 0; i < HALF_W; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end

endmodule

// File: rtl/acc32_stream.sv
// Streaming packet accumulator: low half added on accept, high half one
// cycle later through a registered carry, one total emitted per packet.
module acc32_stream
  import acc32_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  acc32_stream_if.slave s_if
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e state_q, state_d;

  logic [HALF_W-1:0] acc_lo_q, acc_lo_d;
  logic [HALF_W-1:0] acc_hi_q, acc_hi_d;
  logic [HALF_W-1:0] x_hi_q, x_hi_d;
  logic              c_q, c_d;
  logic              pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [HALF_W-1:0] lo_sum, hi_sum;
  logic              lo_co, hi_co;
  logic              in_ready, out_valid;
  logic              accept, done;

  add16 u_lo (
    .a_i    (acc_lo_q),
    .b_i    (s_if.in_data[HALF_W-1:0]),
    .cin_i  (1'b0),
    .sum_o  (lo_sum),
    .cout_o (lo_co)
  );

  add16 u_hi (
    .a_i    (acc_hi_q),
    .b_i    (x_hi_q),
    .cin_i  (c_q),
    .sum_o  (hi_sum),
    .cout_o (hi_co)
  );

  assign accept = s_if.in_valid && in_ready;
  assign done   = out_valid && s_if.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (accept && s_if.in_last) state_d = FLUSH;
      FLUSH:   state_d = HOLD;
      HOLD:    if (s_if.out_ready) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      state_q == RUN:  in_ready  = 1'b1;
      state_q == HOLD: out_valid = 1'b1;
      default: ;
    endcase
  end

  // A new beat may overlap the previous beat's high add in the same cycle.
  always_comb begin
    acc_lo_d = acc_lo_q;
    acc_hi_d = acc_hi_q;
    x_hi_d   = x_hi_q;
    c_d      = c_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    if (pend_q) begin
      acc_hi_d = hi_sum;
      ovf_d    = ovf_q | hi_co;
      pend_d   = 1'b0;
    end
    if (accept) begin
      acc_lo_d = lo_sum;
      c_d      = lo_co;
      x_hi_d   = s_if.in_data[DATA_W-1:HALF_W];
      pend_d   = 1'b1;
      if (cnt_q != CntMax) cnt_d = cnt_q + CntOne;
    end
    if (done) begin
      acc_lo_d = '0;
      acc_hi_d = '0;
      x_hi_d   = '0;
      c_d      = 1'b0;
      pend_d   = 1'b0;
      ovf_d    = 1'b0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_lo_q <= '0;
      acc_hi_q <= '0;
      x_hi_q   <= '0;
      c_q      <= 1'b0;
      pend_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      acc_lo_q <= acc_lo_d;
      acc_hi_q <= acc_hi_d;
      x_hi_q   <= x_hi_d;
      c_q      <= c_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign s_if.in_ready  = in_ready;
  assign s_if.out_valid = out_valid;
  assign s_if.out_sum   = {acc_hi_q, acc_lo_q};
  assign s_if.out_ovf   = ovf_q;
  assign s_if.out_cnt   = cnt_q;

endmodule

// File: tb/tb_acc32_stream.sv
// Directed bench for acc32_stream: two instances (CNT_W 8 and 2) share
// one stimulus so beat-counter saturation is observed alongside the sums.
module tb_acc32_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  acc32_stream_if #(.CNT_W(8)) b8 ();
  acc32_stream_if #(.CNT_W(2)) b2 ();

  assign b8.in_valid  = in_valid;
  assign b8.in_data   = in_data;
  assign b8.in_last   = in_last;
  assign b8.out_ready = out_ready;
  assign b2.in_valid  = in_valid;
  assign b2.in_data   = in_data;
  assign b2.in_last   = in_last;
  assign b2.out_ready = out_ready;

  acc32_stream #(.CNT_W(8)) u8 (.clk(clk), .rst_n(rst_n), .s_if(b8));
  acc32_stream #(.CNT_W(2)) u2 (.clk(clk), .rst_n(rst_n), .s_if(b2));

  always #5 clk = ~clk;

  typedef struct {
    int          first;
    int          n;
    logic [31:0] sum;
    logic        ovf;
    int          cnt;
    int          hold;
  } vec_t;

  logic [31:0] words [0:19];
  int          gaps  [0:19];
  vec_t        vecs  [0:7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " in_ready"},  32'(b8.in_ready), 32'd1);
    chk({tag, " out_valid"}, 32'(b8.out_valid), 32'd0);
    chk({tag, " out_sum"},   b8.out_sum, 32'd0);
    chk({tag, " out_ovf"},   32'(b8.out_ovf), 32'd0);
    chk({tag, " out_cnt"},   32'(b8.out_cnt), 32'd0);
    chk({tag, " cnt2"},      32'(b2.out_cnt), 32'd0);
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    chk("beat in_ready", 32'(b8.in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    int   c2;
    v  = vecs[k];
    c2 = (v.cnt > 3) ? 3 : v.cnt;
    for (int i = 0; i < v.n; i++) begin
      repeat (gaps[v.first + i]) @(negedge clk);
      beat(words[v.first + i], i == v.n - 1);
    end
    // FLUSH cycle: junk on the input must be ignored
    in_valid  = 1'b1;
    in_data   = 32'hFFFF_FFFF;
    in_last   = 1'b1;
    out_ready = (v.hold == 0);
    chk($sformatf("v%0d flush in_ready", k), 32'(b8.in_ready), 32'd0);
    chk($sformatf("v%0d flush out_valid", k), 32'(b8.out_valid), 32'd0);
    @(negedge clk);
    for (int h = 0; h <= v.hold; h++) begin
      if (h == v.hold) out_ready = 1'b1;
      chk($sformatf("v%0d h%0d out_valid", k, h), 32'(b8.out_valid), 32'd1);
      chk($sformatf("v%0d h%0d in_ready", k, h), 32'(b8.in_ready), 32'd0);
      chk($sformatf("v%0d h%0d out_sum", k, h), b8.out_sum, v.sum);
      chk($sformatf("v%0d h%0d out_ovf", k, h), 32'(b8.out_ovf), 32'(v.ovf));
      chk($sformatf("v%0d h%0d out_cnt", k, h), 32'(b8.out_cnt), 32'(v.cnt));
      chk($sformatf("v%0d h%0d cnt2", k, h), 32'(b2.out_cnt), 32'(c2));
      chk($sformatf("v%0d h%0d sum2", k, h), b2.out_sum, v.sum);
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    chk_idle($sformatf("v%0d after", k));
  endtask

  initial begin
    words[0]  = 32'h0000_FFFF; gaps[0]  = 0;
    words[1]  = 32'h0000_FFFF; gaps[1]  = 0;
    words[2]  = 32'h0000_0001; gaps[2]  = 0;
    words[3]  = 32'hFFFF_FFFF; gaps[3]  = 0;
    words[4]  = 32'h0000_0002; gaps[4]  = 0;
    words[5]  = 32'h0000_0005; gaps[5]  = 0;
    words[6]  = 32'h0000_0001; gaps[6]  = 0;
    words[7]  = 32'h0000_0002; gaps[7]  = 1;
    words[8]  = 32'h0000_0003; gaps[8]  = 2;
    words[9]  = 32'h0000_0004; gaps[9]  = 1;
    words[10] = 32'h1234_5678; gaps[10] = 0;
    words[11] = 32'h1111_1111; gaps[11] = 0;
    for (int i = 12; i < 17; i++) begin
      words[i] = 32'h0001_0001;
      gaps[i]  = 0;
    end
    words[17] = 32'h8000_0000; gaps[17] = 0;
    words[18] = 32'h8000_0000; gaps[18] = 0;
    words[19] = 32'h8000_0000; gaps[19] = 0;

    vecs[0] = '{first: 0,  n: 1, sum: 32'h0000_FFFF, ovf: 0, cnt: 1, hold: 0};
    vecs[1] = '{first: 1,  n: 2, sum: 32'h0001_0000, ovf: 0, cnt: 2, hold: 0};
    vecs[2] = '{first: 3,  n: 2, sum: 32'h0000_0001, ovf: 1, cnt: 2, hold: 0};
    vecs[3] = '{first: 5,  n: 1, sum: 32'h0000_0005, ovf: 0, cnt: 1, hold: 0};
    vecs[4] = '{first: 6,  n: 4, sum: 32'h0000_000A, ovf: 0, cnt: 4, hold: 0};
    vecs[5] = '{first: 10, n: 2, sum: 32'h2345_6789, ovf: 0, cnt: 2, hold: 5};
    vecs[6] = '{first: 12, n: 5, sum: 32'h0005_0005, ovf: 0, cnt: 5, hold: 0};
    vecs[7] = '{first: 17, n: 3, sum: 32'h8000_0000, ovf: 1, cnt: 3, hold: 2};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle("reset");

    for (int k = 0; k < 8; k++) run_vec(k);

    // Reset in the middle of a packet drops the partial sum
    beat(32'h0001_0001, 1'b0);
    beat(32'h0001_0001, 1'b0);
    chk("mid out_cnt", 32'(b8.out_cnt), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle("midrst");

    vecs[0] = '{first: 0, n: 1, sum: 32'h0000_0007, ovf: 0, cnt: 1, hold: 1};
    words[0] = 32'h0000_0007;
    run_vec(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc32_stream.md
# acc32_stream

Streaming 32-bit accumulator that sums a packet of words and emits one total per packet. It is the stage directly upstream of consumers of a finished 32-bit sum. Internally it is the pipelined, sequential use of the team's 16-bit ripple adder: low half per cycle, high half one cycle later via a registered inter-half carry. It accepts one word per cycle with no carry-chain timing penalty beyond 16 bits.

## Interface
- CNT_W, 8, width of the per-packet beat counter
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; synchronous, active-low
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept a word this cycle
- in_data  input  32  word to accumulate (unsigned)
- in_last  input  1  final word of packet
- out_valid  output  1  packet result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  32  packet sum modulo 2^32
- out_ovf  output  1  sticky: a carry left bit 31 during the packet
- out_cnt  output  CNT_W  accepted beats in packet, saturating

## Operation
- States:
  - RUN: accepting words.
  - FLUSH: finishing the pending high-half add.
  - HOLD: presenting the result.
- Reset state is RUN.
- in_ready = (state == RUN). It is combinational from state only and does not depend on in_valid.
- Beat accepted means in_valid && in_ready. On each accepted beat:
  - {c_q, acc_lo} <= acc_lo + in_data[15:0]
  - x_hi_q <= in_data[31:16]
  - hi_pend <= 1
  - out_cnt increments, saturating at 2^CNT_W-1
- Every cycle with hi_pend = 1:
  - {cy, acc_hi} <= acc_hi + x_hi_q + c_q
  - out_ovf <= out_ovf | cy
  - hi_pend clears unless a new beat is accepted in the same cycle.
- Bubbles (in_valid = 0 in RUN) leave acc_lo untouched. The pending high half still completes.
- Accepted beat with in_last = 1: RUN -> FLUSH.
- FLUSH performs the final high add, then goes to HOLD unconditionally.
- HOLD:
  - out_valid = 1.
  - out_sum = {acc_hi, acc_lo}, out_ovf and out_cnt are stable until out_ready.
  - On out_valid && out_ready: acc_lo, acc_hi, c_q, hi_pend, out_ovf and out_cnt all clear, and the state goes to RUN.
- No bypass: in_ready stays 0 during the handshake cycle.
- A single-beat packet (in_last on the first beat) is legal.
- A zero-beat packet does not exist.
- Arithmetic:
  - Unsigned, modulo 2^32.
  - Carry out of bit 15 goes only into the next-cycle high add.
  - Carry out of bit 31 only sets out_ovf.

## Timing
- Throughput: 1 word/cycle within a packet.
- Latency: last beat accepted at edge T -> FLUSH during cycle T+1 -> out_valid high in cycle T+2.
- Inter-packet gap: at least 3 cycles from last beat to the next in_ready (FLUSH, HOLD, handshake).
- Reset values:
  - state RUN, so in_ready = 1 in the first cycle after reset release.
  - out_valid 0, out_sum 0, out_ovf 0, out_cnt 0.
  - hi_pend 0, c_q 0, x_hi_q 0.
- Reset asserted mid-packet or in HOLD discards all partial state at that edge. No result is emitted.
- in_data, in_last and in_valid are ignored when in_ready = 0.
- out_valid never drops without out_ready.

## Structure
- Package acc32_pkg contains:
  - state enum (RUN, FLUSH, HOLD)
  - HALF_W = 16
  - DATA_W = 32
- Sub-module: two instances of the existing add16, one for the low half with cin = 0 and one for the high half with cin = c_q.
- Control FSM and registers live in acc32_stream.

## Test plan
- Single beat 0x0000FFFF with last, out_ready = 1 -> out_valid 2 cycles after acceptance, out_sum 0x0000FFFF, out_cnt 1, out_ovf 0.
- Back-to-back 0x0000FFFF, 0x00000001 (last) -> out_sum 0x00010000, out_ovf 0, out_cnt 2. This checks carry across halves via c_q.
- 0xFFFFFFFF, 0x00000002 (last) -> out_sum 0x00000001, out_ovf 1. The next packet 0x5 (last) gives out_sum 0x5 and out_ovf 0.
- Words 1, 2, 3, 4 with 1-2 cycle in_valid gaps -> out_sum 10 (0x0000000A), out_cnt 4.
- out_ready held low 5 cycles in HOLD -> out_sum, out_ovf and out_cnt stable, in_ready 0 throughout. After the handshake, in_ready = 1 the next cycle and the next packet starts from 0.
- With CNT_W = 2, 5 beats of 0x00010001 -> out_cnt 3, out_sum 0x00050005. Reset asserted after 2 beats of a new packet -> all outputs 0, and the following packet 0x7 (last) gives 0x7.
